// File: rtl/dual_issue_hazard_stage_pkg.sv
// Shared types for the dual-issue hazard stage: slot bundle, bubble constant
// and the PAIR/SECOND issue-state encoding.
package dual_issue_hazard_stage_pkg;

    localparam int REG_W = 5;

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
    } slot_t;

    // All-zero slot so EX-stage forwarding can never match a bubble
    localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/dual_issue_hazard_stage_hazard_compare.sv
// Combinational detector for load-use hazards against the EX slots and for
// intra-pair conflicts that force the ID pair to split.
module hazard_compare
    import dual_issue_hazard_stage_pkg::*;
#(
    parameter int NUM_REGS_ZERO = 0
) (
    input  slot_t ex1_i,
    input  slot_t ex2_i,
    input  slot_t cand1_i,
    input  slot_t cand2_i,
    input  slot_t pair1_i,
    input  slot_t pair2_i,
    input  logic  branch1_i,
    input  logic  branch2_i,
    output logic  load_use_o,
    output logic  pair_conflict_o
);

    localparam logic [REG_W-1:0] ZERO_REG = REG_W'(NUM_REGS_ZERO);

    logic rawHazard;
    logic wawHazard;
    logic memHazard;
    logic unusedFields;

    function automatic logic loadFeeds(input slot_t ex, input slot_t c);
        return ex.valid && ex.memread && ex.regwrite && (ex.rd != ZERO_REG) &&
               c.valid && ((ex.rd == c.rs) || (ex.rd == c.rt));
    endfunction

    always_comb begin
        load_use_o = loadFeeds(ex1_i, cand1_i) || loadFeeds(ex1_i, cand2_i) ||
                     loadFeeds(ex2_i, cand1_i) || loadFeeds(ex2_i, cand2_i);
    end

    assign rawHazard = pair1_i.regwrite && (pair1_i.rd != ZERO_REG) &&
                       ((pair1_i.rd == pair2_i.rs) || (pair1_i.rd == pair2_i.rt));
    assign wawHazard = pair1_i.regwrite && pair2_i.regwrite &&
                       (pair1_i.rd == pair2_i.rd) && (pair1_i.rd != ZERO_REG);
    // Only one data-memory port, so two memory ops can never share a cycle
    assign memHazard = (pair1_i.memread || pair1_i.memwrite) &&
                       (pair2_i.memread || pair2_i.memwrite);

    assign pair_conflict_o = pair1_i.valid && pair2_i.valid &&
                             (rawHazard || wawHazard || memHazard || branch1_i || branch2_i);

    assign unusedFields = ^{ex1_i.memwrite, ex2_i.memwrite,
                            cand1_i.rd, cand1_i.regwrite, cand1_i.memread, cand1_i.memwrite,
                            cand2_i.rd, cand2_i.regwrite, cand2_i.memread, cand2_i.memwrite,
                            pair1_i.rs, pair1_i.rt};

endmodule

// File: rtl/dual_issue_hazard_stage.sv
// Issue/hazard FSM and ID/EX pipeline register for the dual-issue pipeline;
// decides whether both, one or neither ID instruction advances into EX.
module dual_issue_hazard_stage #(
    parameter int REG_W         = dual_issue_hazard_stage_pkg::REG_W,
    parameter int NUM_REGS_ZERO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rt1,
    input  logic [REG_W-1:0] id_rd1,
    input  logic             id_regwrite1,
    input  logic             id_memread1,
    input  logic             id_memwrite1,
    input  logic             id_branch1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rt2,
    input  logic [REG_W-1:0] id_rd2,
    input  logic             id_regwrite2,
    input  logic             id_memread2,
    input  logic             id_memwrite2,
    input  logic             id_branch2,
    input  logic             ex_flush,
    output logic             stall_ifid,
    output logic             split_busy,
    output logic             ex_valid1,
    output logic             ex_valid2,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rt1,
    output logic [REG_W-1:0] ex_rd1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [REG_W-1:0] ex_rt2,
    output logic [REG_W-1:0] ex_rd2,
    output logic             ex_regwrite1,
    output logic             ex_memread1,
    output logic             ex_memwrite1,
    output logic             ex_regwrite2,
    output logic             ex_memread2,
    output logic             ex_memwrite2
);

    import dual_issue_hazard_stage_pkg::*;

    state_e state_q, state_d;
    slot_t  ex1_q, ex1_d;
    slot_t  ex2_q, ex2_d;
    slot_t  inst1, inst2, cand1, cand2;
    logic   loadUse, pairConflict, issueStall;

    always_comb begin
        inst1 = '{valid: 1'b1, rs: id_rs1, rt: id_rt1, rd: id_rd1,
                  regwrite: id_regwrite1, memread: id_memread1, memwrite: id_memwrite1};
        inst2 = '{valid: 1'b1, rs: id_rs2, rt: id_rt2, rd: id_rd2,
                  regwrite: id_regwrite2, memread: id_memread2, memwrite: id_memwrite2};
        cand1 = (state_q == SECOND) ? inst2 : inst1;
        cand2 = (state_q == SECOND) ? BUBBLE : inst2;
    end

    hazard_compare #(
        .NUM_REGS_ZERO(NUM_REGS_ZERO)
    ) u_hazard_compare (
        .ex1_i          (ex1_q),
        .ex2_i          (ex2_q),
        .cand1_i        (cand1),
        .cand2_i        (cand2),
        .pair1_i        (inst1),
        .pair2_i        (inst2),
        .branch1_i      (id_branch1),
        .branch2_i      (id_branch2),
        .load_use_o     (loadUse),
        .pair_conflict_o(pairConflict)
    );

    // Priority: flush, empty ID, load-use bubble, then pair/split issue
    always_comb begin
        state_d    = state_q;
        ex1_d      = BUBBLE;
        ex2_d      = BUBBLE;
        issueStall = 1'b0;
        if (ex_flush || !id_valid) begin
            state_d = PAIR;
        end else if (loadUse) begin
            issueStall = 1'b1;
        end else if (state_q == PAIR) begin
            ex1_d = inst1;
            if (pairConflict) begin
                issueStall = 1'b1;
                state_d    = SECOND;
            end else begin
                ex2_d = inst2;
            end
        end else begin
            ex1_d   = inst2;
            state_d = PAIR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAIR;
            ex1_q   <= BUBBLE;
            ex2_q   <= BUBBLE;
        end else begin
            state_q <= state_d;
            ex1_q   <= ex1_d;
            ex2_q   <= ex2_d;
        end
    end

    // Held low while in reset so IF/ID is never frozen by a stale pair
    assign stall_ifid   = rst_n && issueStall;
    assign split_busy   = (state_q == SECOND);

    assign ex_valid1    = ex1_q.valid;
    assign ex_rs1       = ex1_q.rs;
    assign ex_rt1       = ex1_q.rt;
    assign ex_rd1       = ex1_q.rd;
    assign ex_regwrite1 = ex1_q.regwrite;
    assign ex_memread1  = ex1_q.memread;
    assign ex_memwrite1 = ex1_q.memwrite;

    assign ex_valid2    = ex2_q.valid;
    assign ex_rs2       = ex2_q.rs;
    assign ex_rt2       = ex2_q.rt;
    assign ex_rd2       = ex2_q.rd;
    assign ex_regwrite2 = ex2_q.regwrite;
    assign ex_memread2  = ex2_q.memread;
    assign ex_memwrite2 = ex2_q.memwrite;

endmodule

// File: tb/tb_dual_issue_hazard_stage.sv
// Directed, table-driven bench for dual_issue_hazard_stage with hand-computed
// expectations plus an asynchronous-reset sequence taken mid-split.
module tb_dual_issue_hazard_stage;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rt1, id_rd1, id_rs2, id_rt2, id_rd2;
    logic       id_regwrite1, id_memread1, id_memwrite1, id_branch1;
    logic       id_regwrite2, id_memread2, id_memwrite2, id_branch2;
    logic       ex_flush;
    logic       stall_ifid, split_busy, ex_valid1, ex_valid2;
    logic [4:0] ex_rs1, ex_rt1, ex_rd1, ex_rs2, ex_rt2, ex_rd2;
    logic       ex_regwrite1, ex_memread1, ex_memwrite1;
    logic       ex_regwrite2, ex_memread2, ex_memwrite2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       br;
    } instrT;

    typedef struct {
        logic       idValid;
        instrT      i1;
        instrT      i2;
        logic       flush;
        logic       expStall;
        logic       expSplit;
        logic       expV1;
        logic       expV2;
        logic [4:0] expRd1;
        logic [4:0] expRd2;
        logic [4:0] expRs1;
        logic       expRw1;
        logic       expMr1;
        logic       expRw2;
    } vecT;

    localparam int NUM_VECS = 24;
    vecT vecs [NUM_VECS];

    dual_issue_hazard_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rt1(id_rt1), .id_rd1(id_rd1),
        .id_regwrite1(id_regwrite1), .id_memread1(id_memread1),
        .id_memwrite1(id_memwrite1), .id_branch1(id_branch1),
        .id_rs2(id_rs2), .id_rt2(id_rt2), .id_rd2(id_rd2),
        .id_regwrite2(id_regwrite2), .id_memread2(id_memread2),
        .id_memwrite2(id_memwrite2), .id_branch2(id_branch2),
        .ex_flush(ex_flush), .stall_ifid(stall_ifid), .split_busy(split_busy),
        .ex_valid1(ex_valid1), .ex_valid2(ex_valid2),
        .ex_rs1(ex_rs1), .ex_rt1(ex_rt1), .ex_rd1(ex_rd1),
        .ex_rs2(ex_rs2), .ex_rt2(ex_rt2), .ex_rd2(ex_rd2),
        .ex_regwrite1(ex_regwrite1), .ex_memread1(ex_memread1), .ex_memwrite1(ex_memwrite1),
        .ex_regwrite2(ex_regwrite2), .ex_memread2(ex_memread2), .ex_memwrite2(ex_memwrite2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instrT ins(input int rs, input int rt, input int rd,
                                  input int rw, input int mr, input int mw, input int br);
        instrT r;
        r.rs = 5'(rs);
        r.rt = 5'(rt);
        r.rd = 5'(rd);
        r.rw = (rw != 0);
        r.mr = (mr != 0);
        r.mw = (mw != 0);
        r.br = (br != 0);
        return r;
    endfunction

    function automatic vecT mkv(input int v, input instrT a, input instrT b, input int fl,
                                input int st, input int sp, input int v1, input int v2,
                                input int rd1, input int rd2, input int rs1,
                                input int rw1, input int mr1, input int rw2);
        vecT r;
        r.idValid  = (v != 0);
        r.i1       = a;
        r.i2       = b;
        r.flush    = (fl != 0);
        r.expStall = (st != 0);
        r.expSplit = (sp != 0);
        r.expV1    = (v1 != 0);
        r.expV2    = (v2 != 0);
        r.expRd1   = 5'(rd1);
        r.expRd2   = 5'(rd2);
        r.expRs1   = 5'(rs1);
        r.expRw1   = (rw1 != 0);
        r.expMr1   = (mr1 != 0);
        r.expRw2   = (rw2 != 0);
        return r;
    endfunction

    task automatic applyStimulus(input vecT v);
        id_valid     = v.idValid;
        id_rs1       = v.i1.rs;
        id_rt1       = v.i1.rt;
        id_rd1       = v.i1.rd;
        id_regwrite1 = v.i1.rw;
        id_memread1  = v.i1.mr;
        id_memwrite1 = v.i1.mw;
        id_branch1   = v.i1.br;
        id_rs2       = v.i2.rs;
        id_rt2       = v.i2.rt;
        id_rd2       = v.i2.rd;
        id_regwrite2 = v.i2.rw;
        id_memread2  = v.i2.mr;
        id_memwrite2 = v.i2.mw;
        id_branch2   = v.i2.br;
        ex_flush     = v.flush;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        instrT nop;
        instrT addA, subB, orRaw, lw5, use5, lw0, use0, sw1, lw22, beq1, add23;
        nop   = ins(0, 0, 0, 0, 0, 0, 0);
        addA  = ins(1, 2, 3, 1, 0, 0, 0);
        subB  = ins(4, 5, 6, 1, 0, 0, 0);
        orRaw = ins(3, 4, 7, 1, 0, 0, 0);
        lw5   = ins(1, 0, 5, 1, 1, 0, 0);
        use5  = ins(5, 1, 8, 1, 0, 0, 0);
        lw0   = ins(2, 0, 0, 1, 1, 0, 0);
        use0  = ins(0, 0, 18, 1, 0, 0, 0);
        sw1   = ins(1, 2, 0, 0, 0, 1, 0);
        lw22  = ins(3, 0, 22, 1, 1, 0, 0);
        beq1  = ins(1, 2, 0, 0, 0, 0, 1);
        add23 = ins(24, 25, 23, 1, 0, 0, 0);

        //             v  i1   i2                         fl st sp v1 v2 rd1 rd2 rs1 rw1 mr1 rw2
        vecs[0]  = mkv(1, addA, subB,                     0, 0, 0, 1, 1, 3,  6,  1,  1,  0,  1);
        vecs[1]  = mkv(1, addA, orRaw,                    0, 1, 0, 1, 0, 3,  0,  1,  1,  0,  0);
        vecs[2]  = mkv(1, addA, orRaw,                    0, 0, 1, 1, 0, 7,  0,  3,  1,  0,  0);
        vecs[3]  = mkv(1, lw5, ins(10, 11, 9, 1, 0, 0, 0),0, 0, 0, 1, 1, 5,  9,  1,  1,  1,  1);
        vecs[4]  = mkv(1, use5, ins(13, 14, 12, 1, 0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mkv(1, use5, ins(13, 14, 12, 1, 0, 0, 0), 0, 0, 0, 1, 1, 8, 12, 5, 1, 0, 1);
        vecs[6]  = mkv(1, lw0, ins(16, 17, 15, 1, 0, 0, 0),0, 0, 0, 1, 1, 0,  15, 2,  1,  1,  1);
        vecs[7]  = mkv(1, use0, ins(20, 21, 19, 1, 0, 0, 0),0, 0, 0, 1, 1, 18, 19, 0, 1,  0,  1);
        vecs[8]  = mkv(1, sw1, lw22,                      0, 1, 0, 1, 0, 0,  0,  1,  0,  0,  0);
        vecs[9]  = mkv(1, sw1, lw22,                      1, 0, 1, 0, 0, 0,  0,  0,  0,  0,  0);
        vecs[10] = mkv(1, sw1, lw22,                      0, 1, 0, 1, 0, 0,  0,  1,  0,  0,  0);
        vecs[11] = mkv(0, sw1, lw22,                      0, 0, 1, 0, 0, 0,  0,  0,  0,  0,  0);
        vecs[12] = mkv(1, beq1, add23,                    0, 1, 0, 1, 0, 0,  0,  1,  0,  0,  0);
        vecs[13] = mkv(1, beq1, add23,                    0, 0, 1, 1, 0, 23, 0,  24, 1,  0,  0);
        vecs[14] = mkv(1, ins(1, 2, 26, 1, 0, 0, 0), ins(3, 4, 26, 1, 0, 0, 0), 0, 1, 0, 1, 0, 26, 0, 1, 1, 0, 0);
        vecs[15] = mkv(1, ins(1, 2, 26, 1, 0, 0, 0), ins(3, 4, 26, 1, 0, 0, 0), 0, 0, 1, 1, 0, 26, 0, 3, 1, 0, 0);
        vecs[16] = mkv(1, ins(1, 0, 27, 1, 1, 0, 0), ins(2, 3, 28, 1, 0, 0, 0), 0, 0, 0, 1, 1, 27, 28, 1, 1, 1, 1);
        vecs[17] = mkv(1, ins(27, 1, 29, 1, 0, 0, 0), ins(29, 2, 30, 1, 0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18] = mkv(1, ins(27, 1, 29, 1, 0, 0, 0), ins(29, 2, 30, 1, 0, 0, 0), 0, 1, 0, 1, 0, 29, 0, 27, 1, 0, 0);
        vecs[19] = mkv(1, ins(27, 1, 29, 1, 0, 0, 0), ins(29, 2, 30, 1, 0, 0, 0), 0, 0, 1, 1, 0, 30, 0, 29, 1, 0, 0);
        vecs[20] = mkv(1, ins(2, 3, 1, 1, 0, 0, 0), ins(5, 0, 4, 1, 1, 0, 0), 0, 0, 0, 1, 1, 1, 4, 2, 1, 0, 1);
        vecs[21] = mkv(1, ins(7, 4, 6, 1, 0, 0, 0), nop,  0, 1, 0, 0, 0, 0,  0,  0,  0,  0,  0);
        vecs[22] = mkv(1, ins(7, 4, 6, 1, 0, 0, 0), nop,  0, 0, 0, 1, 1, 6,  0,  7,  1,  0,  0);
        vecs[23] = mkv(1, addA, orRaw,                    1, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0);

        rst_n = 1'b0;
        applyStimulus(mkv(0, nop, nop, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        checkOutput("reset ex_valid1", ex_valid1, 0);
        checkOutput("reset ex_valid2", ex_valid2, 0);
        checkOutput("reset ex_rd1", ex_rd1, 0);
        checkOutput("reset ex_regwrite2", ex_regwrite2, 0);
        checkOutput("reset split_busy", split_busy, 0);
        checkOutput("reset stall_ifid", stall_ifid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d stall_ifid", i), stall_ifid, vecs[i].expStall);
            checkOutput($sformatf("v%0d split_busy", i), split_busy, vecs[i].expSplit);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d ex_valid1", i), ex_valid1, vecs[i].expV1);
            checkOutput($sformatf("v%0d ex_valid2", i), ex_valid2, vecs[i].expV2);
            checkOutput($sformatf("v%0d ex_rd1", i), ex_rd1, vecs[i].expRd1);
            checkOutput($sformatf("v%0d ex_rd2", i), ex_rd2, vecs[i].expRd2);
            checkOutput($sformatf("v%0d ex_rs1", i), ex_rs1, vecs[i].expRs1);
            checkOutput($sformatf("v%0d ex_regwrite1", i), ex_regwrite1, vecs[i].expRw1);
            checkOutput($sformatf("v%0d ex_memread1", i), ex_memread1, vecs[i].expMr1);
            checkOutput($sformatf("v%0d ex_regwrite2", i), ex_regwrite2, vecs[i].expRw2);
        end

        // Asynchronous reset taken while the split is pending
        @(negedge clk);
        applyStimulus(mkv(1, addA, orRaw, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("split stall_ifid", stall_ifid, 1);
        @(posedge clk);
        #1;
        checkOutput("split ex_rd1", ex_rd1, 3);
        #2;
        checkOutput("split split_busy", split_busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async ex_valid1", ex_valid1, 0);
        checkOutput("async ex_rd1", ex_rd1, 0);
        checkOutput("async ex_rs1", ex_rs1, 0);
        checkOutput("async ex_regwrite1", ex_regwrite1, 0);
        checkOutput("async split_busy", split_busy, 0);
        checkOutput("async stall_ifid", stall_ifid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkv(1, addA, subB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("post-reset stall_ifid", stall_ifid, 0);
        checkOutput("post-reset split_busy", split_busy, 0);
        @(posedge clk);
        #1;
        checkOutput("post-reset ex_valid1", ex_valid1, 1);
        checkOutput("post-reset ex_valid2", ex_valid2, 1);
        checkOutput("post-reset ex_rd1", ex_rd1, 3);
        checkOutput("post-reset ex_rd2", ex_rd2, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
